vga_box_mixer: RTL and testbench



---
 rtl/vga_mixer_pkg.sv | 38 +++
 rtl/vga_box_motion.sv | 149 ++++++++++++++
 rtl/vga_box_mixer.sv | 147 ++++++++++++++
 tb/tb_vga_box_mixer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_mixer_pkg
// Description : Shared pixel colour type, fixed palette and colour-index
//               helpers for the VGA box mixer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_mixer_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t BG_COLOR     = rgb_t'(12'h003);
    localparam rgb_t BORDER_COLOR = rgb_t'(12'hFFF);
    localparam rgb_t BLANK_COLOR  = rgb_t'(12'h000);

    localparam logic [2:0] c_idx_reset = 3'd1;
    localparam logic [2:0] c_idx_max   = 3'd7;

    // bit2 drives red, bit1 green, bit0 blue at full intensity
    function automatic rgb_t idx_to_rgb(input logic [2:0] idx);
        rgb_t c;
        c.r = {4{idx[2]}};
        c.g = {4{idx[1]}};
        c.b = {4{idx[0]}};
        return c;
    endfunction

    // Index 0 would draw a black box, so the sequence runs 1..7 only
    function automatic logic [2:0] next_color_idx(input logic [2:0] idx);
        return (idx == c_idx_max) ? c_idx_reset : idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_box_motion.sv
`default_nettype none
// ============================================================================
// Module      : vga_box_motion
// Description : Frame-tick detector plus bouncing box position, direction
//               and colour index, updated once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_box_motion
    import vga_mixer_pkg::*;
#(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int BOX_W      = 32,
    parameter int BOX_H      = 32,
    parameter int SPEED      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_vsync,
    input  logic                  i_move_en,
    output logic [HPOS_WIDTH-1:0] o_box_x,
    output logic [VPOS_WIDTH-1:0] o_box_y,
    output logic [2:0]            o_color_idx,
    output logic                  o_frame_tick
);

    localparam int XW = HPOS_WIDTH + 1;
    localparam int YW = VPOS_WIDTH + 1;

    localparam logic [XW-1:0] c_h_disp = XW'(H_DISPLAY);
    localparam logic [XW-1:0] c_box_w  = XW'(BOX_W);
    localparam logic [XW-1:0] c_spd_x  = XW'(SPEED);
    localparam logic [XW-1:0] c_x_max  = XW'(H_DISPLAY - BOX_W);
    localparam logic [YW-1:0] c_v_disp = YW'(V_DISPLAY);
    localparam logic [YW-1:0] c_box_h  = YW'(BOX_H);
    localparam logic [YW-1:0] c_spd_y  = YW'(SPEED);
    localparam logic [YW-1:0] c_y_max  = YW'(V_DISPLAY - BOX_H);

    logic                  r_vs_prev;
    logic                  r_armed;
    logic                  r_tick;
    logic [HPOS_WIDTH-1:0] r_x;
    logic [VPOS_WIDTH-1:0] r_y;
    logic                  r_dir_x;
    logic                  r_dir_y;
    logic [2:0]            r_color_idx;

    logic                  w_tick_det;
    logic [XW-1:0]         w_x_ext;
    logic [XW-1:0]         w_x_step;
    logic [HPOS_WIDTH-1:0] w_x_next;
    logic                  w_dir_x_next;
    logic                  w_bounce_x;
    logic [YW-1:0]         w_y_ext;
    logic [YW-1:0]         w_y_step;
    logic [VPOS_WIDTH-1:0] w_y_next;
    logic                  w_dir_y_next;
    logic                  w_bounce_y;

    // r_armed masks the first cycle after reset so a vsync already low at
    // release is not mistaken for a falling edge
    assign w_tick_det = r_armed & r_vs_prev & ~i_vsync;

    always_comb begin
        w_x_ext      = {1'b0, r_x};
        w_x_step     = w_x_ext;
        w_dir_x_next = r_dir_x;
        w_bounce_x   = 1'b0;
        if (r_dir_x) begin
            if (w_x_ext + c_box_w + c_spd_x >= c_h_disp) begin
                w_x_step     = c_x_max;
                w_dir_x_next = 1'b0;
                w_bounce_x   = 1'b1;
            end else begin
                w_x_step = w_x_ext + c_spd_x;
            end
        end else begin
            if (w_x_ext <= c_spd_x) begin
                w_x_step     = '0;
                w_dir_x_next = 1'b1;
                w_bounce_x   = 1'b1;
            end else begin
                w_x_step = w_x_ext - c_spd_x;
            end
        end
        w_x_next = w_x_step[HPOS_WIDTH-1:0];
    end

    always_comb begin
        w_y_ext      = {1'b0, r_y};
        w_y_step     = w_y_ext;
        w_dir_y_next = r_dir_y;
        w_bounce_y   = 1'b0;
        if (r_dir_y) begin
            if (w_y_ext + c_box_h + c_spd_y >= c_v_disp) begin
                w_y_step     = c_y_max;
                w_dir_y_next = 1'b0;
                w_bounce_y   = 1'b1;
            end else begin
                w_y_step = w_y_ext + c_spd_y;
            end
        end else begin
            if (w_y_ext <= c_spd_y) begin
                w_y_step     = '0;
                w_dir_y_next = 1'b1;
                w_bounce_y   = 1'b1;
            end else begin
                w_y_step = w_y_ext - c_spd_y;
            end
        end
        w_y_next = w_y_step[VPOS_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev   <= 1'b1;
            r_armed     <= 1'b0;
            r_tick      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_color_idx <= c_idx_reset;
        end else begin
            r_vs_prev <= i_vsync;
            r_armed   <= 1'b1;
            r_tick    <= w_tick_det;
            // The tick lands in vertical blanking, so the box never moves mid-scan
            if (r_tick && i_move_en) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_dir_x <= w_dir_x_next;
                r_dir_y <= w_dir_y_next;
                if (w_bounce_x || w_bounce_y) begin
                    r_color_idx <= next_color_idx(r_color_idx);
                end
            end
        end
    end

    assign o_box_x      = r_x;
    assign o_box_y      = r_y;
    assign o_color_idx  = r_color_idx;
    assign o_frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_box_mixer.sv
`default_nettype none
// ============================================================================
// Module      : vga_box_mixer
// Description : Two-stage pixel pipeline drawing a background and a bouncing
//               bordered box, with syncs delayed to stay pixel-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_box_mixer
    import vga_mixer_pkg::*;
#(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480,
    parameter int BOX_W      = 32,
    parameter int BOX_H      = 32,
    parameter int SPEED      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  display_on,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    input  logic                  move_en,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  frame_tick
);

    localparam int XW = HPOS_WIDTH + 1;
    localparam int YW = VPOS_WIDTH + 1;

    localparam logic [XW-1:0] c_box_w    = XW'(BOX_W);
    localparam logic [XW-1:0] c_box_w_m1 = XW'(BOX_W - 1);
    localparam logic [YW-1:0] c_box_h    = YW'(BOX_H);
    localparam logic [YW-1:0] c_box_h_m1 = YW'(BOX_H - 1);

    logic [HPOS_WIDTH-1:0] w_box_x;
    logic [VPOS_WIDTH-1:0] w_box_y;
    logic [2:0]            w_color_idx;

    logic [XW-1:0] w_h_ext;
    logic [XW-1:0] w_bx_ext;
    logic [YW-1:0] w_v_ext;
    logic [YW-1:0] w_by_ext;
    logic          w_in_h;
    logic          w_in_v;
    logic          w_edge_h;
    logic          w_edge_v;
    logic          w_inside;
    logic          w_border;
    rgb_t          w_pix;

    logic          r_s1_inside;
    logic          r_s1_border;
    logic          r_s1_de;
    logic          r_s1_hs;
    logic          r_s1_vs;
    rgb_t          r_rgb;
    logic          r_hs;
    logic          r_vs;

    vga_box_motion #(
        .HPOS_WIDTH (HPOS_WIDTH),
        .VPOS_WIDTH (VPOS_WIDTH),
        .H_DISPLAY  (H_DISPLAY),
        .V_DISPLAY  (V_DISPLAY),
        .BOX_W      (BOX_W),
        .BOX_H      (BOX_H),
        .SPEED      (SPEED)
    ) u_motion (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_vsync      (vsync),
        .i_move_en    (move_en),
        .o_box_x      (w_box_x),
        .o_box_y      (w_box_y),
        .o_color_idx  (w_color_idx),
        .o_frame_tick (frame_tick)
    );

    // Widened by one bit so box_x + BOX_W never wraps at the right/bottom edge
    always_comb begin
        w_h_ext  = {1'b0, hpos};
        w_bx_ext = {1'b0, w_box_x};
        w_v_ext  = {1'b0, vpos};
        w_by_ext = {1'b0, w_box_y};
        w_in_h   = (w_h_ext >= w_bx_ext) && (w_h_ext < w_bx_ext + c_box_w);
        w_in_v   = (w_v_ext >= w_by_ext) && (w_v_ext < w_by_ext + c_box_h);
        w_edge_h = (w_h_ext == w_bx_ext) || (w_h_ext == w_bx_ext + c_box_w_m1);
        w_edge_v = (w_v_ext == w_by_ext) || (w_v_ext == w_by_ext + c_box_h_m1);
        w_inside = w_in_h && w_in_v;
        w_border = w_inside && (w_edge_h || w_edge_v);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_inside <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
        end else begin
            r_s1_inside <= w_inside;
            r_s1_border <= w_border;
            r_s1_de     <= display_on;
            r_s1_hs     <= hsync;
            r_s1_vs     <= vsync;
        end
    end

    always_comb begin
        w_pix = BG_COLOR;
        if (!r_s1_de) begin
            w_pix = BLANK_COLOR;
        end else if (r_s1_border) begin
            w_pix = BORDER_COLOR;
        end else if (r_s1_inside) begin
            w_pix = idx_to_rgb(w_color_idx);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= BLANK_COLOR;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_rgb <= w_pix;
            r_hs  <= r_s1_hs;
            r_vs  <= r_s1_vs;
        end
    end

    assign vga_r  = r_rgb.r;
    assign vga_g  = r_rgb.g;
    assign vga_b  = r_rgb.b;
    assign vga_hs = r_hs;
    assign vga_vs = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_box_mixer
// Description : Scoreboard bench for vga_box_mixer with a reference model of
//               box motion, colour index and pixel classification.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_box_mixer;

    localparam int HD = 640;
    localparam int VD = 480;
    localparam int BW = 32;
    localparam int BH = 32;
    localparam int SP = 2;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic       hsync      = 1'b1;
    logic       vsync      = 1'b1;
    logic       display_on = 1'b0;
    logic [9:0] hpos       = '0;
    logic [9:0] vpos       = '0;
    logic       move_en    = 1'b1;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       frame_tick;

    vga_box_mixer #(
        .HPOS_WIDTH (10),
        .VPOS_WIDTH (10),
        .H_DISPLAY  (HD),
        .V_DISPLAY  (VD),
        .BOX_W      (BW),
        .BOX_H      (BH),
        .SPEED      (SP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .move_en    (move_en),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic [1:0]  sync;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_ticks = 0;

    int   mx, my, midx;
    bit   mdx, mdy;
    bit   m_vsp, m_armed, exp_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; midx = 1; mdx = 1'b1; mdy = 1'b1;
        m_vsp = 1'b1; m_armed = 1'b0; exp_tick = 1'b0;
        q.delete();
    endtask

    task automatic model_move();
        bit b;
        b = 1'b0;
        if (mdx) begin
            if (mx + BW + SP >= HD) begin mx = HD - BW; mdx = 1'b0; b = 1'b1; end
            else mx = mx + SP;
        end else begin
            if (mx <= SP) begin mx = 0; mdx = 1'b1; b = 1'b1; end
            else mx = mx - SP;
        end
        if (mdy) begin
            if (my + BH + SP >= VD) begin my = VD - BH; mdy = 1'b0; b = 1'b1; end
            else my = my + SP;
        end else begin
            if (my <= SP) begin my = 0; mdy = 1'b1; b = 1'b1; end
            else my = my - SP;
        end
        if (b) midx = (midx == 7) ? 1 : midx + 1;
    endtask

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic de);
        bit ins, bor;
        if (!de) return 12'h000;
        ins = (h >= mx) && (h < mx + BW) && (v >= my) && (v < my + BH);
        bor = ins && ((h == mx) || (h == mx + BW - 1) || (v == my) || (v == my + BH - 1));
        if (bor) return 12'hFFF;
        if (ins) return {(midx & 4) != 0 ? 4'hF : 4'h0,
                         (midx & 2) != 0 ? 4'hF : 4'h0,
                         (midx & 1) != 0 ? 4'hF : 4'h0};
        return 12'h003;
    endfunction

    // One pixel clock: check what is due, then drive and predict the next pixel
    task automatic step(input logic hs, input logic vs, input logic de, input int h, input int v);
        exp_t e;
        bit   tick_now;
        @(negedge clk);
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        if (frame_tick) n_ticks++;
        if (q.size() >= 2) begin
            e = q.pop_front();
            check("rgb", {20'h0, vga_r, vga_g, vga_b}, {20'h0, e.rgb});
            check("sync", {30'h0, vga_hs, vga_vs}, {30'h0, e.sync});
        end
        reset_n    = 1'b1;
        hsync      = hs;
        vsync      = vs;
        display_on = de;
        hpos       = 10'(h);
        vpos       = 10'(v);
        e.rgb  = exp_rgb(h, v, de);
        e.sync = {hs, vs};
        q.push_back(e);
        tick_now = exp_tick;
        exp_tick = m_armed & m_vsp & ~vs;
        m_vsp    = vs;
        m_armed  = 1'b1;
        if (tick_now && move_en) model_move();
    endtask

    task automatic hold_reset();
        @(negedge clk);
        check("rst_rgb", {20'h0, vga_r, vga_g, vga_b}, 32'h0);
        check("rst_sync", {30'h0, vga_hs, vga_vs}, 32'h3);
        check("rst_tick", 32'(frame_tick), 32'h0);
        hsync      = 1'($urandom_range(0, 1));
        vsync      = 1'($urandom_range(0, 1));
        display_on = 1'($urandom_range(0, 1));
        hpos       = 10'($urandom_range(0, 1023));
        vpos       = 10'($urandom_range(0, 1023));
        move_en    = 1'($urandom_range(0, 1));
    endtask

    task automatic probe(input int h, input int v, input logic de);
        step(1'($urandom_range(0, 1)), 1'b1, de, h, v);
    endtask

    task automatic do_tick();
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0, 0);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0);
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0, 0);
    endtask

    task automatic probe_box();
        probe(mx + 5, my + 5, 1'b1);
        probe(mx, my + 7, 1'b1);
        probe(mx + BW - 1, my + BH - 1, 1'b1);
        probe(mx + BW, my + 3, 1'b1);
        probe(mx + 3, my + BH, 1'b1);
        probe(mx + 4, my + 4, 1'b0);
    endtask

    initial begin : main
        int t0;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (4) hold_reset();
        move_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 0, 0);

        probe(5, 5, 1'b1);
        probe(0, 10, 1'b1);
        probe(31, 10, 1'b1);
        probe(10, 0, 1'b1);
        probe(10, 31, 1'b1);
        probe(40, 10, 1'b1);
        probe(5, 5, 1'b0);
        probe(32, 5, 1'b1);
        probe(5, 32, 1'b1);

        move_en = 1'b0;
        t0 = n_ticks;
        repeat (5) do_tick();
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check("freeze_ticks", 32'(n_ticks - t0), 32'd5);
        probe_box();

        move_en = 1'b1;
        repeat (1300) begin
            do_tick();
            probe_box();
        end

        probe(mx + 5, my + 5, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rgb", {20'h0, vga_r, vga_g, vga_b}, 32'h0);
        check("async_sync", {30'h0, vga_hs, vga_vs}, 32'h3);
        check("async_tick", 32'(frame_tick), 32'h0);
        model_reset();
        repeat (3) hold_reset();
        move_en = 1'b1;
        t0 = n_ticks;
        step(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0);
        check("no_tick_low_release", 32'(n_ticks - t0), 32'd0);
        do_tick();
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check("tick_after_release", 32'(n_ticks - t0), 32'd1);
        probe_box();
        repeat (3) step(1'b1, 1'b1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
